// File: rtl/timer_counter_mc.sv
`timescale 1ns/1ps
// timer_counter_mc
// Multi-channel memory-mapped timer/counter peripheral for the MIPS system bus.
// Each of NUM_CH channels is an independent down-counter with an 8-bit-max
// prescaler, one-shot or periodic mode, and a sticky expiry flag (W1C).
// A free-running 32-bit timestamp and an interrupt summary register are
// provided in the global region. One OR-ed interrupt line goes to the CPU.
//
// Register map (byte addresses, Addr[1:0] ignored):
//   c*0x10 + 0x0  CTRL  (RW) bit0 EN, bit1 MODE (1=periodic), bit2 IE, [15:8] PRE
//   c*0x10 + 0x4  LOAD  (RW) CNT_W bits, zero-extended
//   c*0x10 + 0x8  COUNT (RO)
//   c*0x10 + 0xC  STAT  bit0 EXP, write 1 to clear
//   0x100         IRQ   (RO) bit c = EXP[c] & IE[c]
//   0x104         TSTAMP(RO) free-running cycle counter
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   CS_N     chip select (active low)
//   RD_N     read strobe (active low)
//   WR_N     write strobe (active low)
//   Addr     12-bit byte address
//   DataIn   32-bit write data
//   DataOut  32-bit read data, combinational, 0 unless a read is strobed
//   Intr     interrupt request, active high, from registered state only
module timer_counter_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr
);

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_LOAD  = 2'd1,
    REG_COUNT = 2'd2,
    REG_STAT  = 2'd3
  } reg_off_e;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic       bus_wr;
  logic       bus_rd;
  logic       chan_space;
  logic       glob_space;
  logic       ch_valid;
  logic [3:0] ch_idx;
  reg_off_e   reg_off;
  logic       unused_bits;

  assign bus_wr     = ~CS_N & ~WR_N;
  assign bus_rd     = ~CS_N & ~RD_N;
  // Only the low 512-byte window is decoded; Addr[11:9] != 0 is unmapped.
  assign chan_space = (Addr[11:8] == 4'h0);
  assign glob_space = (Addr[11:8] == 4'h1);
  assign ch_idx     = Addr[7:4];
  assign reg_off    = reg_off_e'(Addr[3:2]);
  assign ch_valid   = chan_space & (int'(ch_idx) < NUM_CH);
  assign unused_bits = ^{Addr[1:0], DataIn};

  // ---------------------------------------------------------------------
  // Per-channel state, exported as flat vectors/arrays for the read mux
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] en_v;
  logic [NUM_CH-1:0] mode_v;
  logic [NUM_CH-1:0] ie_v;
  logic [NUM_CH-1:0] exp_v;
  logic [PRE_W-1:0]  pre_v   [NUM_CH];
  logic [CNT_W-1:0]  load_v  [NUM_CH];
  logic [CNT_W-1:0]  count_v [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             en_q;
    logic             mode_q;
    logic             ie_q;
    logic             exp_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] count_q;

    logic hit;
    logic load_wr;
    logic ctrl_wr;
    logic stat_wr;
    logic en_new;
    logic run;
    logic tick;
    logic expire;

    assign hit     = bus_wr & ch_valid & (ch_idx == 4'(c));
    assign load_wr = hit & (reg_off == REG_LOAD);
    assign ctrl_wr = hit & (reg_off == REG_CTRL);
    assign stat_wr = hit & (reg_off == REG_STAT);

    // EN as it will be after this edge if software writes CTRL now.
    assign en_new = ctrl_wr ? DataIn[0] : en_q;
    // The prescaler only advances when the channel was already running and
    // is not being stopped this cycle; a LOAD write suppresses the tick.
    assign run    = en_q & en_new & ~load_wr;
    assign tick   = run & (pre_cnt_q == pre_q);
    assign expire = tick & (count_q == '0);

    // NOTE: every state flop is cleared by the asynchronous reset, so Intr
    // and all readback drop the moment reset asserts, without a clock.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        en_q      <= 1'b0;
        mode_q    <= 1'b0;
        ie_q      <= 1'b0;
        exp_q     <= 1'b0;
        pre_q     <= '0;
        pre_cnt_q <= '0;
        load_q    <= '0;
        count_q   <= '0;
      end else begin
        // NOTE: non-blocking assignments throughout, so every branch below
        // reads the pre-edge state regardless of statement order.
        if (load_wr) begin
          load_q    <= DataIn[CNT_W-1:0];
          count_q   <= DataIn[CNT_W-1:0];
          pre_cnt_q <= '0;
        end else begin
          if (run) begin
            pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
          end else if (ctrl_wr & DataIn[0] & ~en_q) begin
            pre_cnt_q <= '0;
          end

          if (tick) begin
            if (!expire) begin
              count_q <= count_q - 1'b1;
            end else if (mode_q) begin
              count_q <= load_q;
            end
          end
        end

        // A CTRL write in the same cycle as a one-shot expiry keeps the
        // value software wrote; otherwise the one-shot stops itself.
        if (ctrl_wr) begin
          en_q   <= DataIn[0];
          mode_q <= DataIn[1];
          ie_q   <= DataIn[2];
          pre_q  <= DataIn[8 +: PRE_W];
        end else if (expire & ~mode_q) begin
          en_q <= 1'b0;
        end

        // Set beats clear when W1C and expiry coincide.
        exp_q <= expire | (exp_q & ~(stat_wr & DataIn[0]));
      end
    end

    assign en_v[c]    = en_q;
    assign mode_v[c]  = mode_q;
    assign ie_v[c]    = ie_q;
    assign exp_v[c]   = exp_q;
    assign pre_v[c]   = pre_q;
    assign load_v[c]  = load_q;
    assign count_v[c] = count_q;
  end

  // ---------------------------------------------------------------------
  // Global timestamp
  // ---------------------------------------------------------------------
  logic [31:0] tstamp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tstamp_q <= '0;
    end else begin
      tstamp_q <= tstamp_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt and read mux
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] irq_vec;
  logic [31:0]       rd_data;

  assign irq_vec = exp_v & ie_v;
  assign Intr    = |irq_vec;

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch forms.
    rd_data = '0;
    if (ch_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (reg_off)
            REG_CTRL: begin
              rd_data[0]          = en_v[c];
              rd_data[1]          = mode_v[c];
              rd_data[2]          = ie_v[c];
              rd_data[8 +: PRE_W] = pre_v[c];
            end
            REG_LOAD:  rd_data[CNT_W-1:0] = load_v[c];
            REG_COUNT: rd_data[CNT_W-1:0] = count_v[c];
            REG_STAT:  rd_data[0]         = exp_v[c];
            default:   rd_data            = '0;
          endcase
        end
      end
    end else if (glob_space) begin
      if (Addr[7:2] == 6'd0) begin
        rd_data[NUM_CH-1:0] = irq_vec;
      end else if (Addr[7:2] == 6'd1) begin
        rd_data = tstamp_q;
      end
    end
  end

  assign DataOut = bus_rd ? rd_data : 32'h0;

endmodule

// File: tb/tb_timer_counter_mc.sv
`timescale 1ns/1ps
// Testbench for timer_counter_mc: directed sequences with fixed expected
// values, then randomized bus traffic checked against a cycle-level
// behavioural model. Read data and Intr are compared by a monitor that pops
// expectations queued by the stimulus side.
module tb_timer_counter_mc;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n, rd_n, wr_n;
  logic [11:0] addr;
  logic [31:0] din, dout;
  logic        intr;
  logic        s_cs_n, s_rd_n, s_wr_n;
  logic [11:0] s_addr;
  logic [31:0] s_din, s_dout;
  logic        s_intr;

  always #5 clk = ~clk;

  timer_counter_mc #(.NUM_CH(4), .CNT_W(32), .PRE_W(8)) dut (
    .clk(clk), .reset(reset), .CS_N(cs_n), .RD_N(rd_n), .WR_N(wr_n),
    .Addr(addr), .DataIn(din), .DataOut(dout), .Intr(intr)
  );

  timer_counter_mc #(.NUM_CH(2), .CNT_W(8), .PRE_W(8)) dut_s (
    .clk(clk), .reset(reset), .CS_N(s_cs_n), .RD_N(s_rd_n), .WR_N(s_wr_n),
    .Addr(s_addr), .DataIn(s_din), .DataOut(s_dout), .Intr(s_intr)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit mon_on = 1'b0;

  logic [31:0] rd_q[$];
  logic [11:0] rd_addr_q[$];
  logic        intr_q[$];
  logic        mon_e;
  logic [31:0] mon_d;
  logic [11:0] mon_a;

  // ---------------- reference model ----------------
  bit          m_en[NCH], m_mode[NCH], m_ie[NCH], m_exp[NCH];
  int unsigned m_pre[NCH], m_pc[NCH];
  logic [31:0] m_load[NCH], m_cnt[NCH];
  logic [31:0] m_ts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_ie[c] = 0; m_exp[c] = 0;
      m_pre[c] = 0; m_pc[c] = 0; m_load[c] = 0; m_cnt[c] = 0;
    end
    m_ts = 0;
  endfunction

  function automatic bit model_intr();
    bit v;
    v = 0;
    for (int c = 0; c < NCH; c++) v = v | (m_exp[c] & m_ie[c]);
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    int ch;
    v = 0;
    if (a[11:8] == 4'h1) begin
      if (a[7:2] == 6'd0) begin
        for (int c = 0; c < NCH; c++) v[c] = m_exp[c] & m_ie[c];
      end else if (a[7:2] == 6'd1) begin
        v = m_ts;
      end
    end else if (a[11:8] == 4'h0) begin
      ch = int'(a[7:4]);
      if (ch < NCH) begin
        case (a[3:2])
          2'd0: begin
            v[0] = m_en[ch]; v[1] = m_mode[ch]; v[2] = m_ie[ch];
            v[15:8] = m_pre[ch][7:0];
          end
          2'd1: v = m_load[ch];
          2'd2: v = m_cnt[ch];
          default: v[0] = m_exp[ch];
        endcase
      end
    end
    return v;
  endfunction

  // One clock edge of the specified behaviour, given the bus write (if any).
  function automatic void model_step(input bit w, input logic [11:0] a, input logic [31:0] d);
    bit hit, lw, cw, sw, was_en, keep_en, fired;
    m_ts = m_ts + 1;
    for (int c = 0; c < NCH; c++) begin
      hit   = w && (a[11:8] == 4'h0) && (int'(a[7:4]) == c);
      lw    = hit && (a[3:2] == 2'd1);
      cw    = hit && (a[3:2] == 2'd0);
      sw    = hit && (a[3:2] == 2'd3);
      fired = 0;
      if (lw) begin
        m_load[c] = d; m_cnt[c] = d; m_pc[c] = 0;
      end else begin
        was_en  = m_en[c];
        keep_en = cw ? d[0] : was_en;
        if (was_en && keep_en) begin
          if (m_pc[c] == m_pre[c]) begin
            m_pc[c] = 0;
            if (m_cnt[c] != 0) m_cnt[c] = m_cnt[c] - 1;
            else begin
              fired = 1;
              if (m_mode[c]) m_cnt[c] = m_load[c];
              else if (!cw) m_en[c] = 0;
            end
          end else begin
            m_pc[c] = (m_pc[c] + 1) % 256;
          end
        end else if (cw && d[0] && !was_en) begin
          m_pc[c] = 0;
        end
      end
      if (cw) begin
        m_en[c] = d[0]; m_mode[c] = d[1]; m_ie[c] = d[2]; m_pre[c] = d[15:8];
      end
      if (sw && d[0]) m_exp[c] = 0;
      if (fired) m_exp[c] = 1;
    end
  endfunction

  // ---------------- stimulus side ----------------
  task automatic tick_once(input bit use_c, input logic [31:0] cval);
    intr_q.push_back(model_intr());
    if (!cs_n && !rd_n) begin
      rd_q.push_back(use_c ? cval : model_read(addr));
      rd_addr_q.push_back(addr);
    end
    @(posedge clk);
    model_step(!cs_n && !wr_n, addr, din);
    #1;
  endtask

  task automatic idle();
    cs_n = 1; rd_n = 1; wr_n = 1; addr = 0; din = 0;
    tick_once(0, 0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cs_n = 0; rd_n = 1; wr_n = 0; addr = a; din = d;
    tick_once(0, 0);
  endtask

  task automatic rd(input logic [11:0] a);
    cs_n = 0; rd_n = 0; wr_n = 1; addr = a; din = $urandom;
    tick_once(0, 0);
  endtask

  task automatic rdc(input logic [11:0] a, input logic [31:0] e);
    cs_n = 0; rd_n = 0; wr_n = 1; addr = a; din = 0;
    tick_once(1, e);
  endtask

  task automatic s_wr(input logic [11:0] a, input logic [31:0] d);
    s_cs_n = 0; s_wr_n = 0; s_rd_n = 1; s_addr = a; s_din = d;
    idle();
    s_cs_n = 1; s_wr_n = 1;
  endtask

  task automatic s_rdchk(input string name, input logic [11:0] a, input logic [31:0] e);
    s_cs_n = 0; s_rd_n = 0; s_wr_n = 1; s_addr = a; s_din = 0;
    #1;
    check(name, s_dout, e);
    idle();
    s_cs_n = 1; s_rd_n = 1;
  endtask

  function automatic logic [11:0] rand_addr();
    logic [11:0] a;
    int k;
    a = 12'($urandom);
    k = $urandom_range(0, 19);
    if (k < 14)      a[11:4] = 8'($urandom_range(0, 3));
    else if (k < 16) a[11:4] = 8'($urandom_range(4, 15));
    else if (k < 19) begin a[11:8] = 4'h1; a[7:2] = 6'($urandom_range(0, 2)); end
    else             a[11:8] = 4'($urandom_range(2, 15));
    return a;
  endfunction

  function automatic logic [31:0] rand_data(input logic [11:0] a);
    logic [31:0] d;
    d = $urandom;
    case (a[3:2])
      2'd0: begin
        d[15:8] = 8'($urandom_range(0, 3));
        d[0]    = ($urandom_range(0, 3) != 0);
      end
      2'd1: if ($urandom_range(0, 9) != 0) d = $urandom_range(0, 6);
      default: ;
    endcase
    return d;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      if (intr_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL intr_queue: got empty expected entry @%0t", $time);
      end else begin
        mon_e = intr_q.pop_front();
        n_vec++;
        if (intr !== mon_e) begin
          n_miss++;
          $display("FAIL intr: got %0b expected %0b @%0t", intr, mon_e, $time);
        end
      end
      if (!cs_n && !rd_n) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL read_queue: got empty expected entry @%0t", $time);
        end else begin
          mon_d = rd_q.pop_front();
          mon_a = rd_addr_q.pop_front();
          n_vec++;
          if (dout !== mon_d) begin
            n_miss++;
            $display("FAIL read 0x%03h: got 0x%08h expected 0x%08h @%0t", mon_a, dout, mon_d, $time);
          end
        end
      end else begin
        n_vec++;
        if (dout !== 32'h0) begin
          n_miss++;
          $display("FAIL idle_dout: got 0x%08h expected 0x00000000 @%0t", dout, $time);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int r;
    logic [11:0] a;
    cs_n = 1; rd_n = 1; wr_n = 1; addr = 0; din = 0;
    s_cs_n = 1; s_rd_n = 1; s_wr_n = 1; s_addr = 0; s_din = 0;
    reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_intr", intr, 0);
    check("rst_dout_idle", dout, 0);
    cs_n = 0; rd_n = 0; addr = 12'h104;
    #1;
    check("rst_tstamp_read", dout, 0);
    #1;
    reset = 1;
    model_reset();
    mon_on = 1;

    // Reset state and timestamp rate
    rdc(12'h104, 0);
    rdc(12'h104, 1);
    for (int ch = 0; ch < NCH; ch++)
      for (int off = 0; off < 4; off++)
        rdc({4'h0, 4'(ch), 2'(off), 2'b00}, 0);
    rdc(12'h100, 0);
    rdc(12'h104, 19);

    // Ch0 periodic LOAD=3, PRE=0
    wr(12'h004, 3);
    wr(12'h000, 32'h7);
    rdc(12'h008, 3);
    rdc(12'h008, 2);
    rdc(12'h008, 1);
    rdc(12'h008, 0);
    rdc(12'h008, 3);
    rdc(12'h100, 1);
    check("ch0_intr", intr, 1);
    // W1C on the very edge of the next expiry: set wins
    idle();
    wr(12'h00C, 1);
    rdc(12'h00C, 1);
    wr(12'h00C, 1);
    rdc(12'h00C, 0);
    wr(12'h000, 0);
    wr(12'h00C, 1);
    check("ch0_off_intr", intr, 0);

    // Ch1 one-shot LOAD=2, PRE=2: expiry 9 cycles after enable
    wr(12'h014, 2);
    wr(12'h010, 32'h0205);
    repeat (8) idle();
    check("ch1_intr_before", intr, 0);
    idle();
    check("ch1_intr_expire", intr, 1);
    rdc(12'h010, 32'h0204);
    rdc(12'h018, 0);
    repeat (5) idle();
    rdc(12'h018, 0);
    check("ch1_intr_held", intr, 1);
    wr(12'h01C, 1);
    check("ch1_intr_clr", intr, 0);
    wr(12'h010, 0);

    // Narrow build: 2 channels, 8-bit counters
    for (int i = 0; i < 8; i++) s_wr(12'h020 + 12'(4 * i), 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) s_rdchk("s_unmapped", 12'h020 + 12'(4 * i), 0);
    for (int i = 0; i < 8; i++) s_rdchk("s_untouched", 12'(4 * i), 0);
    s_wr(12'h004, 32'h1FF);
    s_rdchk("s_load_trunc", 12'h004, 32'hFF);
    s_rdchk("s_count_trunc", 12'h008, 32'hFF);
    check("s_intr", s_intr, 0);

    // Reset in the middle of counting with Intr high
    wr(12'h004, 5);
    wr(12'h000, 32'h7);
    wr(12'h014, 2);
    wr(12'h010, 32'h0107);
    repeat (20) idle();
    check("mid_intr_high", intr, 1);
    mon_on = 0;
    cs_n = 0; rd_n = 0; wr_n = 1; addr = 12'h008;
    #1;
    reset = 0;
    #1;
    check("async_rst_intr", intr, 0);
    check("async_rst_count", dout, 0);
    addr = 12'h100;
    #1;
    check("async_rst_irq", dout, 0);
    rd_q.delete(); rd_addr_q.delete(); intr_q.delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1;
    model_reset();
    mon_on = 1;
    repeat (10) idle();
    rdc(12'h000, 0);
    rdc(12'h008, 0);
    rdc(12'h018, 0);
    check("post_rst_intr", intr, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        rd(rand_addr());
      end else if (r < 75) begin
        a = rand_addr();
        wr(a, rand_data(a));
      end else begin
        idle();
      end
    end
    idle();
    idle();
    mon_on = 0;
    check("read_queue_drained", 32'(rd_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/timer_counter_mc.md
# timer_counter_mc

Parametrised multi-channel memory-mapped timer/counter peripheral for the MIPS system bus. It decodes the same chip-select/read/write strobe interface as the existing single timer. It provides NUM_CH independent down-counters, each with:
- an 8-bit prescaler,
- one-shot or periodic mode,
- a sticky expiry flag with write-1-to-clear.

It drives one OR-ed interrupt line toward the CPU and sits behind the address decoder's timer chip select.

## Interface
Parameters:
- NUM_CH, 4, number of channels (1..8)
- CNT_W, 32, counter/load width in bits (8..32)
- PRE_W, 8, prescaler width in bits (1..8)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- CS_N  in  1  chip select, active low
- RD_N  in  1  read strobe, active low
- WR_N  in  1  write strobe, active low
- Addr  in  12  byte address; Addr[1:0] ignored
- DataIn  in  32  write data
- DataOut  out  32  read data, combinational
- Intr  out  1  interrupt request, active high

## Operation
Register map, per channel c at base c*0x10 (Addr[8]=0, Addr[7:4]=c):
- +0x0 CTRL (RW)
  - bit0 EN
  - bit1 MODE: 0 one-shot, 1 periodic
  - bit2 IE
  - bits[15:8] PRE, only the low PRE_W bits are stored
- +0x4 LOAD (RW), CNT_W bits, zero-extended on read
- +0x8 COUNT (RO)
- +0xC STAT (bit0 EXP); writing 1 to bit0 clears EXP

Global registers (Addr[8]=1):
- 0x100 IRQ (RO): bit c = EXP[c] & IE[c]
- 0x104 TSTAMP (RO): free-running 32-bit cycle counter, wraps 0xFFFFFFFF -> 0

Bus rules:
- Write occurs at the rising edge where CS_N=0 and WR_N=0.
- DataOut is the selected register when CS_N=0 and RD_N=0, otherwise 32'h0.
- Channel index >= NUM_CH and unmapped offsets read 0; writes to them are ignored.
- Writes to RO registers are ignored.
- Reads have no side effects.

Channel behaviour, in priority order per cycle:
- LOAD write: LOAD and COUNT both take DataIn[CNT_W-1:0]; prescaler cleared; no tick is processed that cycle.
- CTRL write with EN 0->1: prescaler cleared.
- Prescaler:
  - runs while EN=1 and counts 0..PRE.
  - A tick is generated in the cycle the prescaler equals PRE; the prescaler then wraps to 0.
  - PRE=0 means a tick every cycle.
- On tick with COUNT != 0: COUNT <= COUNT-1.
- On tick with COUNT == 0:
  - EXP <= 1.
  - Periodic: COUNT <= LOAD.
  - One-shot: EN <= 0 and COUNT holds 0.
- Expiry period is therefore (LOAD+1)*(PRE+1) cycles.
- EN=0: prescaler and COUNT frozen.

Intr = OR over c of (EXP[c] & IE[c]); driven from registered state, no combinational path from the bus.

## Timing
- Reset values:
  - CTRL=0, LOAD=0, COUNT=0, EXP=0
  - prescalers=0, TSTAMP=0
  - Intr=0
  - DataOut=0 (strobes inactive)
- Read latency: 0 cycles (combinational); value reflects state before the current edge.
- Written register value is visible from the cycle after the write edge.
- EXP and Intr rise one cycle after the expiring tick edge (registered).
- Simultaneous STAT W1C and new expiry in the same cycle: set wins, EXP stays 1.
- Simultaneous LOAD write and tick: LOAD write wins, no decrement, no expiry.
- CTRL write clearing EN on a tick cycle: the tick is discarded.
- One-shot re-arm: software writes LOAD, then sets EN.
- Reset asserted mid-count: all channels return to reset values asynchronously; Intr drops immediately.

## Test plan
- Reset then read every register -> all read 0; Intr=0; TSTAMP increments by 1 per cycle after reset release.
- Ch0 LOAD=3, CTRL=0x7 (EN, periodic, IE, PRE=0) -> COUNT reads 3,2,1,0,3,...; EXP and Intr set every 4 cycles; IRQ reads 0x1.
- Ch1 LOAD=2, CTRL=0x0205 (one-shot, IE, PRE=2) -> expiry after exactly 9 cycles; CTRL.EN reads 0 afterwards; COUNT stays 0; Intr=1 until STAT written 0x1, then 0.
- W1C to STAT coinciding with a periodic expiry on ch0 -> EXP remains 1; a second W1C clears it.
- NUM_CH=2 build: read/write 0x20..0x3C -> reads 0, no state change; CNT_W=8 build with LOAD write 0x1FF -> LOAD reads 0xFF.
- Assert reset with two channels mid-count and Intr=1 -> Intr and all outputs 0 without a clock edge; counting resumes only after reprogramming.
